// File: rtl/divisor_nb.sv
// divisor_nb: push-button driven restoring divider.
//   The operator enters a numerator and then a denominator with up/down and
//   confirms each one with ok. The divider then produces one quotient bit per
//   clock. It traps a zero denominator, and ok toggles the display between the
//   quotient and the remainder.
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   up/down   entry increment/decrement buttons (level in, edge-detected here)
//   ok        confirm / Q-R toggle button (level in, edge-detected here)
//   leds      entry value, quotient, remainder, or all ones on error
//   busy      high while the division runs (exactly WIDTH cycles)
//   done      one-cycle pulse on the first SHOW_Q cycle
//   err       high while the denominator-zero trap is active
//   show_rem  high while leds shows the remainder
//
// state    | meaning
// LOAD_NUM | editing numerator, leds = entry
// LOAD_DEN | editing denominator, leds = entry
// CALC     | restoring division, one bit per cycle, leds = 0
// SHOW_Q   | leds = quotient
// SHOW_R   | leds = remainder
// ERR      | denominator was zero, leds = all ones
module divisor_nb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up,
    input  logic             down,
    input  logic             ok,
    output logic [WIDTH-1:0] leds,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             show_rem
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

    localparam logic [2:0] S_LOAD_NUM = 3'd0;
    localparam logic [2:0] S_LOAD_DEN = 3'd1;
    localparam logic [2:0] S_CALC     = 3'd2;
    localparam logic [2:0] S_SHOW_Q   = 3'd3;
    localparam logic [2:0] S_SHOW_R   = 3'd4;
    localparam logic [2:0] S_ERR      = 3'd5;

    logic [2:0]       state;
    logic [WIDTH-1:0] entry, entry_next;
    logic [WIDTH-1:0] num, den, q, r;
    logic [WIDTH-1:0] p;
    logic [CW-1:0]    cnt;
    logic             up_q, down_q, ok_q;
    logic             up_p, down_p, ok_p;
    logic [WIDTH:0]   p_shift, diff;
    logic             p_ge;
    logic [WIDTH-1:0] p_next;

    assign up_p   = up & ~up_q;
    assign down_p = down & ~down_q;
    assign ok_p   = ok & ~ok_q;

    always_comb begin
        entry_next = entry;
        if (up_p && !down_p)
            entry_next = entry + WIDTH'(1);
        else if (down_p && !up_p)
            entry_next = entry - WIDTH'(1);
    end

    // The partial remainder is always below den, so the shifted value is below
    // 2*den. When the shifted value is less than den, the WIDTH+1 bit difference
    // wraps and its top bit is set. When it is greater or equal, the difference
    // is below den and the top bit is clear. The top bit is therefore the borrow.
    assign p_shift = {p, num[cnt]};
    assign diff    = p_shift - {1'b0, den};
    assign p_ge    = ~diff[WIDTH];
    assign p_next  = p_ge ? diff[WIDTH-1:0] : p_shift[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_LOAD_NUM;
            entry  <= '0;
            num    <= '0;
            den    <= '0;
            q      <= '0;
            r      <= '0;
            p      <= '0;
            cnt    <= '0;
            up_q   <= 1'b0;
            down_q <= 1'b0;
            ok_q   <= 1'b0;
            done   <= 1'b0;
        end else begin
            up_q   <= up;
            down_q <= down;
            ok_q   <= ok;
            done   <= 1'b0;
            case (state)
                S_LOAD_NUM: begin
                    if (ok_p) begin
                        num   <= entry;
                        entry <= '0;
                        state <= S_LOAD_DEN;
                    end else begin
                        entry <= entry_next;
                    end
                end
                S_LOAD_DEN: begin
                    if (ok_p) begin
                        den   <= entry;
                        entry <= '0;
                        if (entry == '0) begin
                            state <= S_ERR;
                        end else begin
                            state <= S_CALC;
                            cnt   <= CNT_TOP;
                            p     <= '0;
                            q     <= '0;
                        end
                    end else begin
                        entry <= entry_next;
                    end
                end
                S_CALC: begin
                    p      <= p_next;
                    q[cnt] <= p_ge;
                    if (cnt == '0) begin
                        r     <= p_next;
                        state <= S_SHOW_Q;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_SHOW_Q, S_SHOW_R: begin
                    // down has priority over ok so that a restart always succeeds.
                    if (down_p) begin
                        entry <= '0;
                        state <= S_LOAD_NUM;
                    end else if (ok_p) begin
                        state <= (state == S_SHOW_Q) ? S_SHOW_R : S_SHOW_Q;
                    end
                end
                S_ERR: begin
                    if (ok_p) begin
                        entry <= '0;
                        state <= S_LOAD_NUM;
                    end
                end
                default: begin
                    entry <= '0;
                    state <= S_LOAD_NUM;
                end
            endcase
        end
    end

    always_comb begin
        leds = '0;
        case (state)
            S_LOAD_NUM, S_LOAD_DEN: leds = entry;
            S_SHOW_Q:               leds = q;
            S_SHOW_R:               leds = r;
            S_ERR:                  leds = '1;
            default:                leds = '0;
        endcase
    end

    assign busy     = (state == S_CALC);
    assign err      = (state == S_ERR);
    assign show_rem = (state == S_SHOW_R);

endmodule

// File: tb/tb_divisor_nb.sv
module tb_divisor_nb;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       up4 = 1'b0, dn4 = 1'b0, ok4 = 1'b0;
    logic       up8 = 1'b0, dn8 = 1'b0, ok8 = 1'b0;
    logic [3:0] leds4;
    logic [7:0] leds8;
    logic       busy4, done4, err4, srem4;
    logic       busy8, done8, err8, srem8;

    int tests = 0;
    int fails = 0;
    int n;

    always #5 clk = ~clk;

    divisor_nb #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .up(up4), .down(dn4), .ok(ok4),
        .leds(leds4), .busy(busy4), .done(done4), .err(err4), .show_rem(srem4)
    );

    divisor_nb #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .up(up8), .down(dn8), .ok(ok8),
        .leds(leds8), .busy(busy8), .done(done8), .err(err8), .show_rem(srem8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // b: 0 up, 1 down, 2 ok, 3 up+down. The button is held high for one cycle.
    task automatic press(input bit w8, input int b);
        @(negedge clk);
        if (w8) begin
            up8 = (b == 0 || b == 3);
            dn8 = (b == 1 || b == 3);
            ok8 = (b == 2);
        end else begin
            up4 = (b == 0 || b == 3);
            dn4 = (b == 1 || b == 3);
            ok4 = (b == 2);
        end
        @(negedge clk);
        up4 = 0; dn4 = 0; ok4 = 0;
        up8 = 0; dn8 = 0; ok8 = 0;
    endtask

    task automatic presses(input bit w8, input int b, input int count);
        for (int i = 0; i < count; i++) press(w8, b);
    endtask

    task automatic wait_busy(input bit w8, output int cycles);
        cycles = 0;
        while ((w8 ? busy8 : busy4) && cycles < 64) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_leds4", 32'(leds4), 0);
        chk("rst_busy4", 32'(busy4), 0);
        chk("rst_done4", 32'(done4), 0);
        chk("rst_err4",  32'(err4), 0);
        chk("rst_srem4", 32'(srem4), 0);
        chk("rst_leds8", 32'(leds8), 0);
        rst = 1'b1;

        // 1: 13 / 4 = 3 r 1
        presses(0, 0, 13);
        chk("t1_num_entry", 32'(leds4), 13);
        press(0, 2);
        presses(0, 0, 4);
        press(0, 2);
        chk("t1_busy_start", 32'(busy4), 1);
        chk("t1_leds_calc", 32'(leds4), 0);
        wait_busy(0, n);
        chk("t1_busy_cycles", 32'(n), 4);
        chk("t1_done", 32'(done4), 1);
        chk("t1_q", 32'(leds4), 3);
        chk("t1_srem_q", 32'(srem4), 0);
        @(negedge clk);
        chk("t1_done_pulse", 32'(done4), 0);
        press(0, 2);
        chk("t1_r", 32'(leds4), 1);
        chk("t1_srem_r", 32'(srem4), 1);
        press(0, 2);
        chk("t1_q_again", 32'(leds4), 3);
        chk("t1_srem_q_again", 32'(srem4), 0);

        // 2: restart from SHOW_Q, then wrap both ways and a held button
        press(0, 1);
        chk("t2_restart", 32'(leds4), 0);
        press(0, 1);
        chk("t2_wrap_down", 32'(leds4), 15);
        press(0, 0);
        chk("t2_wrap_up", 32'(leds4), 0);
        @(negedge clk);
        up4 = 1;
        repeat (5) @(negedge clk);
        up4 = 0;
        chk("t2_held", 32'(leds4), 1);

        // 6a: up+down pressed together
        press(0, 3);
        chk("t6_updown", 32'(leds4), 1);

        // 3: divide by zero
        presses(0, 0, 6);
        chk("t3_num", 32'(leds4), 7);
        press(0, 2);
        chk("t3_den_entry", 32'(leds4), 0);
        press(0, 2);
        chk("t3_err", 32'(err4), 1);
        chk("t3_leds", 32'(leds4), 15);
        chk("t3_busy", 32'(busy4), 0);
        @(negedge clk);
        chk("t3_busy_later", 32'(busy4), 0);
        press(0, 0);
        chk("t3_up_ignored", 32'(leds4), 15);
        press(0, 2);
        chk("t3_exit_leds", 32'(leds4), 0);
        chk("t3_exit_err", 32'(err4), 0);
        press(0, 0);
        chk("t3_edit", 32'(leds4), 1);
        press(0, 1);

        // 6b: ok during CALC ignored; 9 / 2 = 4 r 1; down in SHOW_R restarts
        presses(0, 0, 9);
        press(0, 2);
        presses(0, 0, 2);
        press(0, 2);
        press(0, 2);
        chk("t6_busy_mid", 32'(busy4), 1);
        wait_busy(0, n);
        chk("t6_remaining", 32'(n), 2);
        chk("t6_done", 32'(done4), 1);
        chk("t6_q", 32'(leds4), 4);
        chk("t6_srem_q", 32'(srem4), 0);
        press(0, 2);
        chk("t6_r", 32'(leds4), 1);
        press(0, 1);
        chk("t6_restart_leds", 32'(leds4), 0);
        chk("t6_restart_srem", 32'(srem4), 0);
        press(0, 0);
        chk("t6_restart_edit", 32'(leds4), 1);
        press(0, 1);

        // 5: reset mid-CALC, then 6 / 2
        presses(0, 0, 6);
        press(0, 2);
        presses(0, 0, 2);
        press(0, 2);
        @(negedge clk);
        chk("t5_busy_before", 32'(busy4), 1);
        rst = 1'b0;
        #1;
        chk("t5_busy_rst", 32'(busy4), 0);
        chk("t5_leds_rst", 32'(leds4), 0);
        @(negedge clk);
        rst = 1'b1;
        presses(0, 0, 6);
        chk("t5_num", 32'(leds4), 6);
        press(0, 2);
        presses(0, 0, 2);
        press(0, 2);
        wait_busy(0, n);
        chk("t5_cycles", 32'(n), 4);
        chk("t5_q", 32'(leds4), 3);
        press(0, 2);
        chk("t5_r", 32'(leds4), 0);

        // 4: WIDTH=8, 200 / 7 = 28 r 4 (numerator via wrap-down), then 3 / 9
        presses(1, 1, 56);
        chk("t4_num", 32'(leds8), 200);
        press(1, 2);
        presses(1, 0, 7);
        press(1, 2);
        wait_busy(1, n);
        chk("t4_cycles", 32'(n), 8);
        chk("t4_done", 32'(done8), 1);
        chk("t4_q", 32'(leds8), 28);
        press(1, 2);
        chk("t4_r", 32'(leds8), 4);
        chk("t4_srem", 32'(srem8), 1);
        press(1, 1);
        presses(1, 0, 3);
        press(1, 2);
        presses(1, 0, 9);
        press(1, 2);
        wait_busy(1, n);
        chk("t4b_cycles", 32'(n), 8);
        chk("t4b_q", 32'(leds8), 0);
        press(1, 2);
        chk("t4b_r", 32'(leds8), 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
